// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MIPS memory stage: widths, access-size codes,
// FSM states and the alignment rule.
package mem_stage_pkg;

  localparam int WORD_WIDTH = 32;
  localparam int REG_SIZE   = 5;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } memState_t;

  // Size code 11 is handled as a word, so only byte and half are exempt.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SIZE_BYTE: isMisaligned = 1'b0;
      SIZE_HALF: isMisaligned = addrLo[0];
      default:   isMisaligned = (addrLo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane selection and sign/zero extension of the data-memory read word
// (little-endian lanes).
module load_align
  import mem_stage_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] rdata,
  input  logic [1:0]            addrLo,
  input  logic [1:0]            size,
  input  logic                  isSigned,
  output logic [WORD_WIDTH-1:0] data
);

  logic        [7:0]  byteLane;
  logic        [15:0] halfLane;
  logic signed [7:0]  byteS;
  logic signed [15:0] halfS;

  always_comb begin
    case (addrLo)
      2'd0:    byteLane = rdata[7:0];
      2'd1:    byteLane = rdata[15:8];
      2'd2:    byteLane = rdata[23:16];
      default: byteLane = rdata[31:24];
    endcase
    halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];
    byteS    = $signed(byteLane);
    halfS    = $signed(halfLane);
    case (size)
      SIZE_BYTE: data = isSigned ? WORD_WIDTH'(byteS) : {24'd0, byteLane};
      SIZE_HALF: data = isSigned ? WORD_WIDTH'(halfS) : {16'd0, halfLane};
      default:   data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM and MEM/WB registers, req/ack data-memory access
// with wait states, misalignment and bus-timeout exceptions.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_WIDTH-1:0] aluOutE,
  input  logic [WORD_WIDTH-1:0] writeDataE,
  input  logic [REG_SIZE-1:0]   writeRegAddrE,
  input  logic                  validE,
  input  logic                  regWriteE,
  input  logic                  memReadE,
  input  logic                  memWriteE,
  input  logic                  memSignedE,
  input  logic [1:0]            memSizeE,
  input  logic                  bubbleE,
  output logic                  stallM,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [WORD_WIDTH-1:0] dmem_wdata,
  input  logic [WORD_WIDTH-1:0] dmem_rdata,
  input  logic                  dmem_ack,
  output logic [WORD_WIDTH-1:0] aluOutM,
  output logic [WORD_WIDTH-1:0] memOutM,
  output logic [REG_SIZE-1:0]   writeRegAddrW,
  output logic                  regWriteW,
  output logic                  misalignM,
  output logic                  busErrM
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  logic                  validM, regWriteM, memReadM, memWriteM, memSignedM;
  logic [1:0]            memSizeM;
  logic [WORD_WIDTH-1:0] writeDataM;
  logic [REG_SIZE-1:0]   writeRegAddrM;

  memState_t             state, stateNext;
  logic [CNT_W-1:0]      waitCnt, waitCntNext;
  logic                  accessM, reqAligned, waitDone, abort, loadDone;
  logic [3:0]            beM;
  logic [WORD_WIDTH-1:0] loadData;

  // EX -> M boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validM        <= 1'b0;
      regWriteM     <= 1'b0;
      memReadM      <= 1'b0;
      memWriteM     <= 1'b0;
      memSignedM    <= 1'b0;
      memSizeM      <= 2'b00;
      aluOutM       <= '0;
      writeDataM    <= '0;
      writeRegAddrM <= '0;
    end else if (!stallM) begin
      validM        <= validE & ~bubbleE;
      regWriteM     <= regWriteE;
      memReadM      <= memReadE;
      memWriteM     <= memWriteE;
      memSignedM    <= memSignedE;
      memSizeM      <= memSizeE;
      aluOutM       <= aluOutE;
      writeDataM    <= writeDataE;
      writeRegAddrM <= writeRegAddrE;
    end
  end

  assign accessM    = validM & (memReadM | memWriteM);
  assign misalignM  = accessM & isMisaligned(memSizeM, aluOutM[1:0]);
  assign reqAligned = accessM & ~misalignM;
  assign waitDone   = (waitCnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      ST_IDLE: if (reqAligned && !dmem_ack) begin
        stateNext   = ST_WAIT;
        waitCntNext = CNT_W'(1);
      end
      ST_WAIT: if (dmem_ack || waitDone) begin
        stateNext   = ST_IDLE;
        waitCntNext = '0;
      end else begin
        waitCntNext = waitCnt + CNT_W'(1);
      end
      default: begin
        stateNext   = ST_IDLE;
        waitCntNext = '0;
      end
    endcase
  end

  // A late ack on the timeout cycle still completes the access.
  always_comb begin
    dmem_req = (state == ST_WAIT) | ((state == ST_IDLE) & reqAligned);
    abort    = (state == ST_WAIT) & waitDone & ~dmem_ack;
    stallM   = dmem_req & ~dmem_ack & ~abort;
    busErrM  = abort;
    dmem_we  = dmem_req & memWriteM;
    loadDone = dmem_req & dmem_ack & memReadM;
  end

  always_comb begin
    case (memSizeM)
      SIZE_BYTE: begin
        beM        = 4'b0001 << aluOutM[1:0];
        dmem_wdata = {4{writeDataM[7:0]}};
      end
      SIZE_HALF: begin
        beM        = aluOutM[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {2{writeDataM[15:0]}};
      end
      default: begin
        beM        = 4'b1111;
        dmem_wdata = writeDataM;
      end
    endcase
    dmem_be   = dmem_req ? beM : 4'b0000;
    dmem_addr = {aluOutM[WORD_WIDTH-1:2], 2'b00};
  end

  load_align uLoadAlign (
    .rdata    (dmem_rdata),
    .addrLo   (aluOutM[1:0]),
    .size     (memSizeM),
    .isSigned (memSignedM),
    .data     (loadData)
  );

  // M -> W boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memOutM       <= '0;
      writeRegAddrW <= '0;
      regWriteW     <= 1'b0;
    end else if (stallM) begin
      regWriteW     <= 1'b0;
    end else begin
      memOutM       <= loadDone ? loadData : aluOutM;
      writeRegAddrW <= writeRegAddrM;
      regWriteW     <= regWriteM & validM & ~misalignM & ~busErrM;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads/stores, wait states, misalignment,
// bus timeout and reset during an outstanding access.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] aluOutE, writeDataE, dmem_rdata;
  logic [4:0]  writeRegAddrE;
  logic        validE, regWriteE, memReadE, memWriteE, memSignedE, bubbleE, dmem_ack;
  logic [1:0]  memSizeE;
  logic        stallM, dmem_req, dmem_we, regWriteW, misalignM, busErrM;
  logic [31:0] dmem_addr, dmem_wdata, aluOutM, memOutM;
  logic [3:0]  dmem_be;
  logic [4:0]  writeRegAddrW;

  int checks   = 0;
  int failures = 0;
  int reqCycles;

  mem_stage #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst(rst),
    .aluOutE(aluOutE), .writeDataE(writeDataE), .writeRegAddrE(writeRegAddrE),
    .validE(validE), .regWriteE(regWriteE), .memReadE(memReadE),
    .memWriteE(memWriteE), .memSignedE(memSignedE), .memSizeE(memSizeE),
    .bubbleE(bubbleE), .stallM(stallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .aluOutM(aluOutM),
    .memOutM(memOutM), .writeRegAddrW(writeRegAddrW), .regWriteW(regWriteW),
    .misalignM(misalignM), .busErrM(busErrM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic sgn, input logic regW,
                       input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] ra);
    validE = 1'b1; memReadE = rd; memWriteE = wr; memSignedE = sgn;
    regWriteE = regW; memSizeE = sz; aluOutE = addr; writeDataE = wd;
    writeRegAddrE = ra; bubbleE = 1'b0;
  endtask

  task automatic idleE;
    validE = 1'b0; memReadE = 1'b0; memWriteE = 1'b0; memSignedE = 1'b0;
    regWriteE = 1'b0; memSizeE = 2'b00; aluOutE = '0; writeDataE = '0;
    writeRegAddrE = '0; bubbleE = 1'b0;
  endtask

  initial begin
    idleE();
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    #2 rst = 1'b1;
    tick();
    tick();
    chk("rst_stall", {31'd0, stallM}, 32'd0);
    chk("rst_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_we", {31'd0, dmem_we}, 32'd0);
    chk("rst_be", {28'd0, dmem_be}, 32'd0);
    chk("rst_misalign", {31'd0, misalignM}, 32'd0);
    chk("rst_buserr", {31'd0, busErrM}, 32'd0);
    chk("rst_aluOutM", aluOutM, 32'd0);
    chk("rst_memOutM", memOutM, 32'd0);
    chk("rst_wraddr", {27'd0, writeRegAddrW}, 32'd0);
    chk("rst_regWriteW", {31'd0, regWriteW}, 32'd0);
    rst = 1'b0;
    tick();

    // lb signed, zero-wait
    issue(1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 32'h103, 32'h0, 5'd5);
    tick();
    idleE();
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_1234;
    #1;
    chk("lb_req", {31'd0, dmem_req}, 32'd1);
    chk("lb_addr", dmem_addr, 32'h100);
    chk("lb_be", {28'd0, dmem_be}, 32'h8);
    chk("lb_stall", {31'd0, stallM}, 32'd0);
    tick();
    dmem_ack = 1'b0;
    chk("lb_memOut", memOutM, 32'hFFFF_FF80);
    chk("lb_regWriteW", {31'd0, regWriteW}, 32'd1);
    chk("lb_wraddr", {27'd0, writeRegAddrW}, 32'd5);

    // lbu
    issue(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h103, 32'h0, 5'd6);
    tick();
    idleE();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lbu_memOut", memOutM, 32'h0000_0080);

    // lh signed, upper half
    issue(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 32'h102, 32'h0, 5'd6);
    tick();
    idleE();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lh_memOut", memOutM, 32'hFFFF_80FF);

    // sh
    issue(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, 32'h202, 32'h0000_ABCD, 5'd0);
    tick();
    idleE();
    dmem_ack = 1'b1;
    #1;
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", {31'd0, dmem_we}, 32'd1);
    chk("sh_addr", dmem_addr, 32'h200);
    tick();
    dmem_ack = 1'b0;
    chk("sh_regWriteW", {31'd0, regWriteW}, 32'd0);

    // lw with 3 wait cycles, ALU instruction held in E behind it
    issue(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h300, 32'h0, 5'd7);
    tick();
    issue(1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'h1234, 32'h0, 5'd9);
    for (int i = 0; i < 3; i++) begin
      dmem_ack = 1'b0;
      #1;
      chk("lw3_stall", {31'd0, stallM}, 32'd1);
      chk("lw3_req", {31'd0, dmem_req}, 32'd1);
      chk("lw3_addr", dmem_addr, 32'h300);
      tick();
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("lw3_ack_stall", {31'd0, stallM}, 32'd0);
    tick();
    idleE();
    dmem_ack = 1'b0;
    chk("lw3_memOut", memOutM, 32'hDEAD_BEEF);
    chk("lw3_regWriteW", {31'd0, regWriteW}, 32'd1);
    chk("lw3_wraddr", {27'd0, writeRegAddrW}, 32'd7);
    chk("lw3_next_in_M", aluOutM, 32'h1234);
    tick();
    chk("alu_memOut", memOutM, 32'h1234);
    chk("alu_wraddr", {27'd0, writeRegAddrW}, 32'd9);

    // misaligned lw
    issue(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h101, 32'h0, 5'd8);
    tick();
    idleE();
    #1;
    chk("mis_req", {31'd0, dmem_req}, 32'd0);
    chk("mis_pulse", {31'd0, misalignM}, 32'd1);
    chk("mis_stall", {31'd0, stallM}, 32'd0);
    tick();
    chk("mis_regWriteW", {31'd0, regWriteW}, 32'd0);
    chk("mis_pulse_end", {31'd0, misalignM}, 32'd0);

    // bubble replaces the E instruction
    issue(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h300, 32'h0, 5'd3);
    bubbleE = 1'b1;
    tick();
    idleE();
    #1;
    chk("bub_req", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("bub_regWriteW", {31'd0, regWriteW}, 32'd0);

    // sw never acknowledged -> timeout
    issue(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 32'h400, 32'h55, 5'd0);
    tick();
    idleE();
    reqCycles = 0;
    for (int i = 0; i < 16; i++) begin
      dmem_ack = 1'b0;
      #1;
      if (dmem_req) reqCycles++;
      chk("to_stall", {31'd0, stallM}, (i < 15) ? 32'd1 : 32'd0);
      chk("to_buserr", {31'd0, busErrM}, (i == 15) ? 32'd1 : 32'd0);
      tick();
    end
    chk("to_req_cycles", reqCycles, 32'd16);
    chk("to_req_after", {31'd0, dmem_req}, 32'd0);
    chk("to_buserr_after", {31'd0, busErrM}, 32'd0);

    // lw acknowledged on the final (abort) cycle completes normally
    issue(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h500, 32'h0, 5'd10);
    tick();
    idleE();
    dmem_rdata = 32'h1357_9BDF;
    for (int i = 0; i < 16; i++) begin
      dmem_ack = (i == 15);
      #1;
      chk("late_stall", {31'd0, stallM}, (i < 15) ? 32'd1 : 32'd0);
      chk("late_buserr", {31'd0, busErrM}, 32'd0);
      tick();
    end
    dmem_ack = 1'b0;
    chk("late_memOut", memOutM, 32'h1357_9BDF);
    chk("late_regWriteW", {31'd0, regWriteW}, 32'd1);

    // reset while waiting
    issue(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h600, 32'h0, 5'd11);
    tick();
    idleE();
    tick();
    chk("rw_stall_before", {31'd0, stallM}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_req", {31'd0, dmem_req}, 32'd0);
    chk("rw_stall", {31'd0, stallM}, 32'd0);
    chk("rw_aluOutM", aluOutM, 32'd0);
    chk("rw_memOutM", memOutM, 32'd0);
    chk("rw_wraddr", {27'd0, writeRegAddrW}, 32'd0);
    chk("rw_be", {28'd0, dmem_be}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rw_req_lost", {31'd0, dmem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
